// File: rtl/rtc_pkg.sv
// rtc_pkg: BCD byte type, time limits and digit helpers shared by the RTC core
package rtc_pkg;
   typedef logic [7:0] bcd_t;
   localparam bcd_t SEC_MAX   = 8'h59;
   localparam bcd_t HR24_MAX  = 8'h23;
   localparam bcd_t HR12_NOON = 8'h12;
   function automatic logic bcd_valid(input bcd_t v, input bcd_t max);
      return v[7:4] <= 4'd9 && v[3:0] <= 4'd9 && v <= max;
   endfunction
   function automatic bcd_t to12h(input bcd_t h);
      logic [4:0] d;
      d = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
      d = d == 5'd0 ? 5'd12 : d > 5'd12 ? d - 5'd12 : d;
      return d >= 5'd10 ? {4'd1, 4'(d - 5'd10)} : {4'd0, d[3:0]};
   endfunction
endpackage

// File: rtl/rtc_bcd_core_counter.sv
// bcd_mod_counter: two-digit BCD counter modulo MOD with load and carry-out
module bcd_mod_counter
   import rtc_pkg::*;
#(
   parameter logic [7:0] MOD = 8'h60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] q,
   output logic [7:0] nxt,
   output logic       carry
);
   localparam bcd_t LAST = MOD[3:0] == 4'd0 ? {MOD[7:4] - 4'd1, 4'd9} : MOD - 8'd1;
   bcd_t up;
   always_comb begin
      carry = inc && q == LAST;
      up = carry ? 8'h00 : q[3:0] == 4'd9 ? {q[7:4] + 4'd1, 4'd0} : q + 8'd1;
      nxt = load ? load_val : inc ? up : q;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) q <= '0;
      else q <= nxt;
endmodule

// File: rtl/rtc_bcd_core.sv
// rtc_bcd_core: prescaled BCD clock with 12/24 h display and validated load; minute alarm under RTC_ALARM_EN
module rtc_bcd_core
   import rtc_pkg::*;
#(
   parameter int TICK_DIV = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ena,
   input  logic       mode24,
   input  logic       set_valid,
   input  logic [7:0] set_hh,
   input  logic [7:0] set_mm,
   input  logic [7:0] set_ss,
   output logic       set_err,
   output logic [7:0] hh,
   output logic [7:0] mm,
   output logic [7:0] ss,
   output logic       pm,
   output logic       sec_tick
`ifdef RTC_ALARM_EN
   ,
   input  logic [7:0] alarm_hh,
   input  logic [7:0] alarm_mm,
   input  logic       alarm_arm,
   output logic       alarm
`endif
);
   localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
   logic [PW-1:0] pcnt;
   logic load_ok, tick, inc, c_ss, c_mm, hr_wrap_unused;
   logic [7:0] ss_nxt, mm_nxt, h24, h24_nxt;
   assign load_ok = set_valid && bcd_valid(set_ss, SEC_MAX) && bcd_valid(set_mm, SEC_MAX)
                    && bcd_valid(set_hh, HR24_MAX);
   assign tick = ena && pcnt == PLAST;
   // an accepted load swallows the coincident increment
   assign inc = tick && !load_ok;
   bcd_mod_counter #(.MOD(8'h60)) u_ss (
      .clk(clk), .reset(reset), .inc(inc), .load(load_ok), .load_val(set_ss),
      .q(ss), .nxt(ss_nxt), .carry(c_ss)
   );
   bcd_mod_counter #(.MOD(8'h60)) u_mm (
      .clk(clk), .reset(reset), .inc(c_ss), .load(load_ok), .load_val(set_mm),
      .q(mm), .nxt(mm_nxt), .carry(c_mm)
   );
   bcd_mod_counter #(.MOD(8'h24)) u_hh (
      .clk(clk), .reset(reset), .inc(c_mm), .load(load_ok), .load_val(set_hh),
      .q(h24), .nxt(h24_nxt), .carry(hr_wrap_unused)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) pcnt <= '0;
      else if (load_ok) pcnt <= '0;
      else if (ena) pcnt <= tick ? '0 : pcnt + 1'b1;
   // display is rendered from next-state hours so hh/pm stay registered
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         hh <= HR12_NOON;
         pm <= 1'b0;
         sec_tick <= 1'b0;
         set_err <= 1'b0;
      end else begin
         hh <= mode24 ? h24_nxt : to12h(h24_nxt);
         pm <= h24_nxt >= HR12_NOON;
         sec_tick <= inc;
         set_err <= set_valid && !load_ok;
      end
`ifdef RTC_ALARM_EN
   logic unused_h24;
   assign unused_h24 = ^h24;
   always_ff @(posedge clk or posedge reset)
      if (reset) alarm <= 1'b0;
      else alarm <= inc && alarm_arm && h24_nxt == alarm_hh && mm_nxt == alarm_mm && ss_nxt == 8'h00;
`else
   logic unused_nxt;
   assign unused_nxt = ^{ss_nxt, mm_nxt, h24};
`endif
endmodule

// File: tb/tb_rtc_bcd_core.sv
// tb_rtc_bcd_core: seconds-of-day reference model checks two core instances (TICK_DIV 1 and 4)
module tb_rtc_bcd_core;
   logic clk = 1'b0;
   logic reset, ena, mode24, set_valid;
   logic [7:0] set_hh, set_mm, set_ss;
   logic [7:0] hh[2], mm[2], ss[2];
   logic pm[2], sec_tick[2], set_err[2];
   logic [7:0] alarm_hh, alarm_mm;
   logic alarm_arm;
   logic alarm[2];
   int checks = 0, errors = 0;
   int t[2], pc[2];
   logic [7:0] e_hh[2];
   bit e_pm[2], e_tick[2], e_err[2], e_alarm[2];

   always #5 clk = ~clk;

   rtc_bcd_core #(.TICK_DIV(1)) u1 (
      .clk(clk), .reset(reset), .ena(ena), .mode24(mode24), .set_valid(set_valid),
      .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss), .set_err(set_err[0]),
      .hh(hh[0]), .mm(mm[0]), .ss(ss[0]), .pm(pm[0]), .sec_tick(sec_tick[0])
`ifdef RTC_ALARM_EN
      , .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_arm(alarm_arm), .alarm(alarm[0])
`endif
   );
   rtc_bcd_core #(.TICK_DIV(4)) u4 (
      .clk(clk), .reset(reset), .ena(ena), .mode24(mode24), .set_valid(set_valid),
      .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss), .set_err(set_err[1]),
      .hh(hh[1]), .mm(mm[1]), .ss(ss[1]), .pm(pm[1]), .sec_tick(sec_tick[1])
`ifdef RTC_ALARM_EN
      , .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_arm(alarm_arm), .alarm(alarm[1])
`endif
   );

   function automatic logic [7:0] bcd(int v);
      return 8'((v / 10) * 16 + v % 10);
   endfunction
   function automatic int dec(logic [7:0] v);
      return int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction
   function automatic bit ok(logic [7:0] v, int max);
      return v[7:4] <= 4'd9 && v[3:0] <= 4'd9 && dec(v) <= max;
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit good;
      int h, div;
      good = set_valid && ok(set_hh, 23) && ok(set_mm, 59) && ok(set_ss, 59);
      for (int i = 0; i < 2; i++) begin
         div = i == 0 ? 1 : 4;
         e_tick[i] = 0;
         e_alarm[i] = 0;
         if (reset) begin
            t[i] = 0; pc[i] = 0; e_hh[i] = 8'h12; e_pm[i] = 0; e_err[i] = 0;
         end else begin
            e_err[i] = set_valid && !good;
            if (good) begin
               t[i] = dec(set_hh) * 3600 + dec(set_mm) * 60 + dec(set_ss);
               pc[i] = 0;
            end else if (ena) begin
               pc[i]++;
               if (pc[i] == div) begin
                  pc[i] = 0;
                  t[i] = (t[i] + 1) % 86400;
                  e_tick[i] = 1;
               end
            end
            h = t[i] / 3600;
            e_hh[i] = mode24 ? bcd(h) : bcd(h % 12 == 0 ? 12 : h % 12);
            e_pm[i] = h >= 12;
`ifdef RTC_ALARM_EN
            e_alarm[i] = e_tick[i] && alarm_arm && t[i] == dec(alarm_hh) * 3600 + dec(alarm_mm) * 60;
`endif
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("hh%0d", i), hh[i], e_hh[i]);
         chk($sformatf("mm%0d", i), mm[i], bcd((t[i] / 60) % 60));
         chk($sformatf("ss%0d", i), ss[i], bcd(t[i] % 60));
         chk($sformatf("pm%0d", i), pm[i], e_pm[i]);
         chk($sformatf("sec_tick%0d", i), sec_tick[i], e_tick[i]);
         chk($sformatf("set_err%0d", i), set_err[i], e_err[i]);
`ifdef RTC_ALARM_EN
         chk($sformatf("alarm%0d", i), alarm[i], e_alarm[i]);
`endif
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      set_valid = 1; set_hh = h; set_mm = m; set_ss = s;
      cyc();
      set_valid = 0;
   endtask

   typedef struct {
      logic [7:0] h, m, s;
      bit err;
      logic [7:0] eh, em, es;
      bit epm;
   } vec_t;
   vec_t tbl[10];

   initial begin
      int n, first, last;
      tbl[0] = '{8'h11, 8'h59, 8'h59, 0, 8'h11, 8'h59, 8'h59, 0};
      tbl[1] = '{8'h24, 8'h00, 8'h00, 1, 8'h11, 8'h59, 8'h59, 0};
      tbl[2] = '{8'h10, 8'h60, 8'h00, 1, 8'h11, 8'h59, 8'h59, 0};
      tbl[3] = '{8'h10, 8'h10, 8'h1A, 1, 8'h11, 8'h59, 8'h59, 0};
      tbl[4] = '{8'h23, 8'h59, 8'h59, 0, 8'h11, 8'h59, 8'h59, 1};
      tbl[5] = '{8'h00, 8'h00, 8'h00, 0, 8'h12, 8'h00, 8'h00, 0};
      tbl[6] = '{8'h13, 8'h05, 8'h07, 0, 8'h01, 8'h05, 8'h07, 1};
      tbl[7] = '{8'h1A, 8'h00, 8'h00, 1, 8'h01, 8'h05, 8'h07, 1};
      tbl[8] = '{8'h12, 8'h34, 8'h56, 0, 8'h12, 8'h34, 8'h56, 1};
      tbl[9] = '{8'h20, 8'h00, 8'h00, 0, 8'h08, 8'h00, 8'h00, 1};
      reset = 1; ena = 0; mode24 = 0; set_valid = 0;
      set_hh = 0; set_mm = 0; set_ss = 0;
      alarm_hh = 8'h07; alarm_mm = 8'h30; alarm_arm = 0;
      for (int i = 0; i < 2; i++) begin
         t[i] = 0; pc[i] = 0; e_hh[i] = 8'h12; e_pm[i] = 0;
         e_tick[i] = 0; e_err[i] = 0; e_alarm[i] = 0;
      end
      repeat (2) cyc();
      reset = 0;
      // a full minute at one tick per cycle
      ena = 1; n = 0;
      repeat (60) begin
         cyc();
         n += int'(sec_tick[0]);
      end
      ena = 0;
      chk("min_ticks", n, 60);
      chk("min_ss", ss[0], 8'h00);
      chk("min_mm", mm[0], 8'h01);
      chk("min_hh", hh[0], 8'h12);
      chk("min_pm", pm[0], 0);
      // noon and midnight rollovers
      load(8'h11, 8'h59, 8'h59);
      ena = 1; cyc(); ena = 0;
      chk("noon_hh", hh[0], 8'h12);
      chk("noon_pm", pm[0], 1);
      chk("noon_mm", mm[0], 8'h00);
      load(8'h23, 8'h59, 8'h59);
      ena = 1; cyc(); ena = 0;
      chk("midnight_hh12", hh[0], 8'h12);
      chk("midnight_pm", pm[0], 0);
      mode24 = 1; cyc();
      chk("midnight_hh24", hh[0], 8'h00);
      // mode change re-renders hours without losing time
      load(8'h17, 8'h00, 8'h00);
      chk("h17_24", hh[0], 8'h17);
      mode24 = 0; cyc();
      chk("h17_12", hh[0], 8'h05);
      chk("h17_pm", pm[0], 1);
      chk("h17_ss", ss[0], 8'h00);
      // back-to-back loads, valid and rejected
      for (int i = 0; i < 10; i++) begin
         load(tbl[i].h, tbl[i].m, tbl[i].s);
         chk($sformatf("tbl%0d_err", i), set_err[0], tbl[i].err);
         chk($sformatf("tbl%0d_hh", i), hh[0], tbl[i].eh);
         chk($sformatf("tbl%0d_mm", i), mm[0], tbl[i].em);
         chk($sformatf("tbl%0d_ss", i), ss[0], tbl[i].es);
         chk($sformatf("tbl%0d_pm", i), pm[0], tbl[i].epm);
      end
      // load coincident with a tick
      ena = 1;
      load(8'h09, 8'h08, 8'h07);
      ena = 0;
      chk("coinc_tick", sec_tick[0], 0);
      chk("coinc_hh", hh[0], 8'h09);
      chk("coinc_mm", mm[0], 8'h08);
      chk("coinc_ss", ss[0], 8'h07);
      // divide-by-4 with ena every other cycle
      load(8'h00, 8'h00, 8'h00);
      n = 0; first = -1; last = -1;
      for (int k = 0; k < 32; k++) begin
         ena = k % 2 == 0;
         cyc();
         if (sec_tick[1]) begin
            n++;
            if (first < 0) first = k;
            last = k;
         end
      end
      ena = 0;
      chk("div4_count", n, 4);
      chk("div4_first", first, 6);
      chk("div4_span", last - first, 24);
      // asynchronous reset mid-count, with a load in flight
      ena = 1;
      repeat (3) cyc();
      #3 reset = 1; set_valid = 1; set_hh = 8'h05; set_mm = 8'h05; set_ss = 8'h05;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("arst_ss%0d", i), ss[i], 8'h00);
         chk($sformatf("arst_mm%0d", i), mm[i], 8'h00);
         chk($sformatf("arst_hh%0d", i), hh[i], 8'h12);
         chk($sformatf("arst_pm%0d", i), pm[i], 0);
         chk($sformatf("arst_tick%0d", i), sec_tick[i], 0);
      end
      cyc();
      set_valid = 0; ena = 0; mode24 = 1;
      #2 reset = 0;
      cyc();
      chk("post_rst_hh24", hh[0], 8'h00);
      mode24 = 0;
`ifdef RTC_ALARM_EN
      alarm_arm = 1;
      load(8'h07, 8'h29, 8'h59);
      ena = 1; cyc(); ena = 0;
      chk("alarm_fire", alarm[0], 1);
      cyc();
      chk("alarm_single", alarm[0], 0);
      alarm_arm = 0;
      load(8'h07, 8'h29, 8'h59);
      ena = 1; cyc(); ena = 0;
      chk("alarm_disarmed", alarm[0], 0);
      alarm_arm = 1;
      load(8'h07, 8'h30, 8'h00);
      chk("alarm_on_load", alarm[0], 0);
`endif
      // randomized traffic against the reference model
      for (int k = 0; k < 600; k++) begin
         ena = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 31) == 0) mode24 = ~mode24;
`ifdef RTC_ALARM_EN
         alarm_arm = $urandom_range(0, 3) != 0;
`endif
         set_valid = $urandom_range(0, 15) == 0;
         set_hh = $urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 255)) : bcd($urandom_range(0, 23));
         set_mm = $urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 255)) : bcd($urandom_range(55, 59));
         set_ss = $urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 255)) : bcd($urandom_range(50, 59));
         cyc();
      end
      set_valid = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
